// File: rtl/reg_file_sb.sv
// Register file with a pending-write scoreboard; REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
// Reads are combinational (0 cycles); writes/allocs commit on posedge clk; no backpressure, always accepts.
module reg_file_sb #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 31,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     alloc_en,
    input  logic [AW-1:0]            alloc_addr,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pending,
    output logic [AW:0]              pending_cnt
);

    localparam logic [AW:0]   NREGS = (AW+1)'(NUM_REGS);
    localparam logic [AW-1:0] ZR    = AW'(ZERO_REG);

    function automatic logic idx_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREGS) && (a != ZR);
    endfunction

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [AW-1:0]       ra [NUM_RD];

    logic wr_ok, alloc_ok, cnt_inc, cnt_dec;

    assign wr_ok    = wr_en && idx_ok(wr_addr);
    assign alloc_ok = alloc_en && idx_ok(alloc_addr);
    // A write to the index being re-allocated leaves it pending, so it never decrements.
    assign cnt_inc  = alloc_ok && !pending[alloc_addr];
    assign cnt_dec  = wr_ok && pending[wr_addr] && !(alloc_ok && (alloc_addr == wr_addr));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            if (wr_ok) begin
                regs[wr_addr]    <= wr_data;
                pending[wr_addr] <= 1'b0;
            end
            // Placed after the clear so a same-cycle alloc (new producer) wins.
            if (alloc_ok) begin
                pending[alloc_addr] <= 1'b1;
            end
            pending_cnt <= pending_cnt + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_ra
        assign ra[k] = rd_addr[k*AW +: AW];
    end

    always_comb begin
        rd_data    = '0;
        rd_pending = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (idx_ok(ra[k])) begin
                rd_data[k*DATA_W +: DATA_W] = regs[ra[k]];
                rd_pending[k]               = pending[ra[k]];
`ifdef REGFILE_BYPASS_EN
                if (!reset && wr_ok && (wr_addr == ra[k])) begin
                    rd_data[k*DATA_W +: DATA_W] = wr_data;
                    rd_pending[k]               = alloc_ok && (alloc_addr == ra[k]);
                end
`endif
            end
        end
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 64, register width in bits.
REQ-002 Parameter NUM_REGS, default 32, register count; AW = $clog2(NUM_REGS) derived.
REQ-003 Parameter NUM_RD, default 2, number of read ports.
REQ-004 Parameter ZERO_REG, default 31, index of the hardwired-zero register.
REQ-005 clk  input  1  sole clock; all state updates on posedge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 wr_en  input  1  write strobe.
REQ-008 wr_addr  input  AW  write register index.
REQ-009 wr_data  input  DATA_W  write data.
REQ-010 alloc_en  input  1  mark a register pending (producer issued).
REQ-011 alloc_addr  input  AW  register index to mark pending.
REQ-012 rd_addr  input  NUM_RD*AW  packed read indices; port k at bits [k*AW +: AW].
REQ-013 rd_data  output  NUM_RD*DATA_W  packed read data; port k at [k*DATA_W +: DATA_W].
REQ-014 rd_pending  output  NUM_RD  bit k high when port k's register awaits a write.
REQ-015 pending_cnt  output  AW+1  number of registers currently pending.

Function
REQ-016 Write: at posedge with wr_en=1, reg[wr_addr] <= wr_data; ignored if wr_addr==ZERO_REG or wr_addr>=NUM_REGS.
REQ-017 Read: combinational, zero latency; rd_data port k = reg[rd_addr k].
REQ-018 Reads of ZERO_REG or index >=NUM_REGS return 0 and rd_pending=0.
REQ-019 Any number of read ports may address the same register simultaneously, each returning identical data.
REQ-020 Scoreboard: pending[i] set at posedge when alloc_en=1 and alloc_addr==i; cleared at posedge when wr_en=1 and wr_addr==i.
REQ-021 Same-cycle alloc and write to same index: pending stays/becomes 1 (new producer wins); data still written.
REQ-022 alloc to ZERO_REG or out-of-range index ignored; pending[ZERO_REG] constant 0.
REQ-023 alloc to an already-pending register: no change, no error.
REQ-024 rd_pending[k] = pending[rd_addr k], subject to REQ-030.
REQ-025 pending_cnt: registered, updated same posedge as pending; +1 on new set, -1 on clear, unchanged when both or neither; equals popcount(pending) at all times.
REQ-026 pending_cnt never exceeds NUM_REGS-1 and never underflows (clear of non-pending register does not decrement).

Reset
REQ-027 reset=1 asynchronously forces all registers to 0, all pending bits to 0, pending_cnt to 0, independent of clk.
REQ-028 Hence rd_data=0 and rd_pending=0 on all ports while reset is high; writes/allocs presented during reset are discarded.
REQ-029 Reset asserted mid-operation discards any in-flight write/alloc of that cycle; first update occurs on first posedge after deassertion.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN defined: if wr_en=1 and wr_addr==rd_addr k (valid, not ZERO_REG), rd_data port k = wr_data and rd_pending[k]=0 in the same cycle, unless alloc_en hits the same index, in which case rd_pending[k]=1.
REQ-031 Macro not defined: read ports show only stored state; same-cycle write visible after the posedge.

Verification
REQ-032 Reset then read all indices on every port -> rd_data=0, rd_pending=0, pending_cnt=0.
REQ-033 Write 0xDEAD_BEEF_0000_0001 to r5, next cycle read r5 on ports 0 and 1 -> both 0xDEAD_BEEF_0000_0001; write 0xFFFF... to r31 -> reads r31 = 0.
REQ-034 alloc r3, r7 on successive cycles -> pending_cnt 1 then 2, rd_pending high for r3; write r3 -> pending_cnt=1, rd_pending(r3)=0.
REQ-035 Same-cycle alloc r9 and write r9=0x42 with r9 pending -> pending stays 1, pending_cnt unchanged, r9=0x42.
REQ-036 Write r4=0x55 while reading r4 same cycle -> rd_data=0x55 with REGFILE_BYPASS_EN, previous value without.
REQ-037 alloc r2, assert reset between clock edges -> outputs zero immediately, pending_cnt=0, r2 not pending after release.
